// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths, starvation limit and FSM state type for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned ARB_AW       = 16;
    localparam int unsigned ARB_DW       = 16;
    localparam int unsigned ARB_MAX_WAIT = 3;
    localparam int unsigned ARB_CNT_W    = 4;

    typedef enum logic {
        ARB_NORMAL   = 1'b0,
        ARB_FORCE_IF = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mem_arb_starve.sv
// Starvation guard: counts consecutive denied fetch cycles and forces a fetch win at MAX_WAIT.
module mem_arb_starve
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = ARB_MAX_WAIT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic if_req_i,
    input  logic if_gnt_i,
    output logic force_if_o
);

    localparam logic [ARB_CNT_W-1:0] MaxWait = ARB_CNT_W'(MAX_WAIT);

    arb_state_e           state_q, state_d;
    logic [ARB_CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ARB_NORMAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ARB_NORMAL: begin
                if (if_req_i && !if_gnt_i) begin
                    cnt_d = (cnt_q >= MaxWait) ? MaxWait : cnt_q + ARB_CNT_W'(1);
                    if (cnt_d == MaxWait) state_d = ARB_FORCE_IF;
                end else begin
                    cnt_d = '0;
                end
            end
            ARB_FORCE_IF: begin
                // Leave on the fetch grant, or if fetch gives up before being served.
                if (if_gnt_i || !if_req_i) begin
                    state_d = ARB_NORMAL;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    assign force_if_o = (state_q == ARB_FORCE_IF);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port memory between fetch (read-only) and data (read/write) ports.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned AW       = ARB_AW,
    parameter int unsigned DW       = ARB_DW,
    parameter int unsigned MAX_WAIT = ARB_MAX_WAIT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_wen,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    logic          force_if;
    logic          if_rvalid_q, d_rvalid_q;
    logic [DW-1:0] if_rdata_q, d_rdata_q;

    mem_arb_starve #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk_i      (clk),
        .rst_i      (rst),
        .if_req_i   (if_req),
        .if_gnt_i   (if_gnt),
        .force_if_o (force_if)
    );

    // Data wins conflicts unless fetch has starved; grants are masked while in reset.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!rst) begin
            if (if_req && (!d_req || force_if)) if_gnt = 1'b1;
            else if (d_req)                     d_gnt  = 1'b1;
        end
    end

    always_comb begin
        mem_wen   = d_gnt & d_wen;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_gnt)     mem_addr = if_addr;
        else if (d_gnt) mem_addr = d_addr;
        if (if_gnt || d_gnt) mem_wdata = d_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            if_rvalid_q <= if_gnt;
            d_rvalid_q  <= d_gnt & ~d_wen;
            if (if_gnt)           if_rdata_q <= mem_rdata;
            if (d_gnt && !d_wen)  d_rdata_q  <= mem_rdata;
        end
    end

    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified memory (combinational read, clocked write) between the IF stage (read-only) and the MEM stage (read/write) of the 4-stage pipeline.
- Arbitrates one access per cycle using a req/gnt handshake.
- Drives the memory address, write-enable and write-data.
- Returns registered read data with 1-cycle latency and a starvation guard so fetch cannot be locked out.

Parameters:
- AW, 16, address width (matches `ISIZE`).
- DW, 16, data width (matches `DSIZE`).
- MAX_WAIT, 3, consecutive denied IF cycles before IF is forced to win (range 1..15).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request.
- if_addr  in  AW  fetch address.
- if_gnt  out  1  fetch granted this cycle.
- if_rvalid  out  1  if_rdata valid (cycle after if_gnt).
- if_rdata  out  DW  fetched word.
- d_req  in  1  data request.
- d_wen  in  1  1 = write, 0 = read.
- d_addr  in  AW  data address.
- d_wdata  in  DW  write data.
- d_gnt  out  1  data access granted this cycle; write completes at this clock edge.
- d_rvalid  out  1  d_rdata valid (read only, cycle after d_gnt).
- d_rdata  out  DW  loaded word.
- mem_wen  out  1  to memory wen.
- mem_addr  out  AW  to memory addr.
- mem_wdata  out  DW  to memory data_in.
- mem_rdata  in  DW  from memory data_out (combinational).

Behaviour:
- Reset (async, rst=1):
  - starve_cnt=0, state=NORMAL.
  - if_rvalid=0, d_rvalid=0, if_rdata=0, d_rdata=0.
  - if_gnt, d_gnt and mem_wen forced 0 combinationally while rst=1.
  - No memory write may occur during reset.
- Requester rules:
  - Requesters hold req/addr/wen/wdata stable until they see gnt high at a clock edge.
  - A request counts as granted at the edge where gnt=1.
- Grant logic (combinational from registered state and current reqs):
  - Only if_req: if_gnt=1.
  - Only d_req: d_gnt=1.
  - Both, state=NORMAL: d_gnt=1 (older instruction wins).
  - Both, state=FORCE_IF: if_gnt=1.
  - Neither: no grant; mem_addr=0, mem_wen=0, mem_wdata=0.
  - if_gnt and d_gnt are never high together.
- Memory drive:
  - mem_addr = granted requester's address.
  - mem_wen = d_gnt & d_wen.
  - mem_wdata = d_wdata.
- Read return (latency 1):
  - At the edge of a read grant, mem_rdata is captured into that port's rdata register.
  - That port's rvalid goes high for exactly one cycle.
  - A write grant produces no d_rvalid.
  - rdata holds its last value when rvalid=0.
- Starvation FSM (states NORMAL, FORCE_IF):
  - NORMAL: if if_req & !if_gnt, starve_cnt++ (saturating at MAX_WAIT); else starve_cnt=0. When the increment reaches MAX_WAIT, next state is FORCE_IF.
  - FORCE_IF: the next IF grant returns to NORMAL with starve_cnt=0.
  - FORCE_IF: if if_req drops before being granted, return to NORMAL with starve_cnt=0.
- Back-to-back: a new grant is legal every cycle. Read-after-write to the same address on consecutive grants returns the new data, since the write lands at the grant edge.
- Reset mid-operation: pending rvalid is cleared, no response is produced for the interrupted access, and the requester must re-request.

Decomposition:
- Shared: AW/DW defaults come from the existing `ISIZE`/`DSIZE` macros in define.v.
- Add to define.v: `ARB_MAX_WAIT` default 3, and state encodings `ARB_NORMAL`=1'b0, `ARB_FORCE_IF`=1'b1.
- One natural sub-module: mem_arb_starve (starve_cnt + NORMAL/FORCE_IF FSM; outputs force_if). Top level holds the grant mux and response registers.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with d_req=1, d_wen=1 -> mem_wen=0 immediately, all rvalid=0, no write to memory.
- IF only, if_addr=0x0004, mem word 0x1234 -> if_gnt=1 same cycle; next cycle if_rvalid=1, if_rdata=0x1234; d_rvalid stays 0.
- Data write then read: d_wen=1, d_addr=0x0010, d_wdata=0xBEEF granted; next cycle read 0x0010 -> d_rvalid=1 one cycle later, d_rdata=0xBEEF; no d_rvalid after the write.
- Conflict with MAX_WAIT=3, both requesting continuously:
  - d_gnt cycles 1-3, if_gnt cycle 4, d_gnt cycles 5-7, if_gnt cycle 8.
  - if_gnt and d_gnt never both 1.
- IF withdrawn while FORCE_IF -> FSM returns to NORMAL, starve_cnt=0, next conflict grants data.
- Reset during a read grant cycle -> following cycle rvalid=0; after release, re-request of the same address returns correct data with 1-cycle latency.
